// File: rtl/up_dn_cmd_if.sv
// Button/switch inputs, counter flags and command outputs between the
// command conditioner (master) and the up/down counter plus its board I/O (slave).
interface up_dn_cmd_if #(
  parameter int unsigned WIDTH = 5
);
  logic             BTN_UP;
  logic             BTN_DN;
  logic             BTN_LD;
  logic [WIDTH-1:0] SW;
  logic             High;
  logic             Low;
  logic             Load;
  logic             Up;
  logic             Down;
  logic [WIDTH-1:0] IN;

  modport master (
    input  BTN_UP, BTN_DN, BTN_LD, SW, High, Low,
    output Load, Up, Down, IN
  );

  modport slave (
    output BTN_UP, BTN_DN, BTN_LD, SW, High, Low,
    input  Load, Up, Down, IN
  );
endinterface

// File: rtl/up_dn_cmd_ctrl.sv
// Conditions raw buttons/switches into single-cycle Load/Up/Down commands for
// the up/down counter: sync, debounce, edge detect, auto-repeat, gate, arbitrate.
module up_dn_cmd_ctrl #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned RPT_DELAY  = 8,
  parameter int unsigned RPT_PERIOD = 4
) (
  input logic         CLK,
  input logic         RST,
  up_dn_cmd_if.master bus
);

  localparam int unsigned NBTN    = 3;
  localparam int unsigned NRPT    = 2;
  localparam int unsigned CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned TMR_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(RPT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

  // Bit order everywhere: [0]=up, [1]=down, [2]=load
  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  btn_s1;
  logic [NBTN-1:0]  btn_s2;
  logic [NBTN-1:0]  press;
  logic [NRPT-1:0]  held;
  logic [NRPT-1:0]  rpt_req;
  logic [WIDTH-1:0] sw_s1;
  logic [WIDTH-1:0] sw_s2;

  logic             up_c;
  logic             down_c;
  logic             load_c;
  logic             load_q;
  logic             up_q;
  logic             down_q;
  logic [WIDTH-1:0] in_q;

  assign btn_raw = {bus.BTN_LD, bus.BTN_DN, bus.BTN_UP};

  // Two-flop synchronizers for buttons and switches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= bus.SW;
      sw_s2  <= sw_s1;
    end
  end

  // Per-button debouncer: state flips only after DEB_CYCLES differing samples
  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             db_prev_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q     <= '0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
      end else begin
        db_prev_q <= db_q;
        if (btn_s2[g] == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          db_q  <= btn_s2[g];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign press[g] = db_q & ~db_prev_q;

    if (g < NRPT) begin : g_held
      assign held[g] = db_q;
    end
  end

  // Hold-to-repeat FSM for up and down; release cancels any request due
  for (genvar g = 0; g < NRPT; g++) begin : g_rpt
    rpt_state_e       state_q;
    rpt_state_e       state_nx;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_nx;
    logic             req_c;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q <= IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_nx;
        tmr_q   <= tmr_nx;
      end
    end

    always_comb begin
      state_nx = state_q;
      tmr_nx   = tmr_q;
      req_c    = 1'b0;
      case (state_q)
        IDLE: begin
          if (press[g]) begin
            req_c    = 1'b1;
            state_nx = HOLD;
            tmr_nx   = '0;
          end
        end
        HOLD: begin
          if (!held[g]) begin
            state_nx = IDLE;
            tmr_nx   = '0;
          end else if (tmr_q == DLY_LAST) begin
            req_c    = 1'b1;
            state_nx = RPT;
            tmr_nx   = '0;
          end else begin
            tmr_nx = tmr_q + TMR_W'(1);
          end
        end
        RPT: begin
          if (!held[g]) begin
            state_nx = IDLE;
            tmr_nx   = '0;
          end else if (tmr_q == PER_LAST) begin
            req_c  = 1'b1;
            tmr_nx = '0;
          end else begin
            tmr_nx = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          tmr_nx   = '0;
        end
      endcase
    end

    assign rpt_req[g] = req_c;
  end

  // Saturation gating, then fixed priority Load > Down > Up; losers are dropped
  always_comb begin
    load_c = press[2];
    down_c = rpt_req[1] & ~bus.Low  & ~load_c;
    up_c   = rpt_req[0] & ~bus.High & ~load_c & ~down_c;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_q <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      in_q   <= '0;
    end else begin
      load_q <= load_c;
      up_q   <= up_c;
      down_q <= down_c;
      if (load_c) begin
        in_q <= sw_s2;
      end
    end
  end

  assign bus.Load = load_q;
  assign bus.Up   = up_q;
  assign bus.Down = down_q;
  assign bus.IN   = in_q;

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Testbench for up_dn_cmd_ctrl: directed scenarios plus random button activity,
// every cycle compared against a press-age based reference model.
module tb_up_dn_cmd_ctrl;

  localparam int W   = 5;
  localparam int DEB = 4;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  up_dn_cmd_if #(.WIDTH(W)) bus ();

  up_dn_cmd_ctrl #(
    .WIDTH      (W),
    .DEB_CYCLES (DEB),
    .RPT_DELAY  (DLY),
    .RPT_PERIOD (PER)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: a button is debounced once its synchronized value has
  // disagreed with the stable value for DEB samples in a row; a held up/down
  // press requests at age 0, DLY, DLY+PER, DLY+2*PER, ...
  logic [2:0]   m_s1, m_s2, m_db, m_dbp;
  int           m_run [3];
  int           m_age [2];
  logic [W-1:0] m_sw1, m_sw2, e_in;
  logic         e_ld, e_up, e_dn;

  logic [2:0]   t_raw, t_db;
  int           t_run [3];
  int           t_age [2];
  logic         t_req [2];
  logic         t_ld, t_up, t_dn;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_s1  <= '0;
      m_s2  <= '0;
      m_db  <= '0;
      m_dbp <= '0;
      m_sw1 <= '0;
      m_sw2 <= '0;
      e_in  <= '0;
      e_ld  <= 1'b0;
      e_up  <= 1'b0;
      e_dn  <= 1'b0;
      m_run <= '{0, 0, 0};
      m_age <= '{-1, -1};
    end else begin
      t_raw = {bus.BTN_LD, bus.BTN_DN, bus.BTN_UP};
      for (int i = 0; i < 2; i++) begin
        t_req[i] = 1'b0;
        t_age[i] = m_age[i];
        if (m_age[i] < 0) begin
          if (m_db[i] && !m_dbp[i]) begin
            t_req[i] = 1'b1;
            t_age[i] = 1;
          end
        end else if (!m_db[i]) begin
          t_age[i] = -1;
        end else begin
          t_req[i] = (m_age[i] == DLY) || (m_age[i] > DLY && ((m_age[i] - DLY) % PER) == 0);
          t_age[i] = m_age[i] + 1;
        end
      end
      t_ld = m_db[2] && !m_dbp[2];
      t_dn = t_req[1] && !bus.Low && !t_ld;
      t_up = t_req[0] && !bus.High && !t_ld && !t_dn;
      for (int i = 0; i < 3; i++) begin
        t_db[i]  = m_db[i];
        t_run[i] = (m_s2[i] != m_db[i]) ? m_run[i] + 1 : 0;
        if (t_run[i] == DEB) begin
          t_db[i]  = m_s2[i];
          t_run[i] = 0;
        end
      end
      e_ld  <= t_ld;
      e_dn  <= t_dn;
      e_up  <= t_up;
      if (t_ld) e_in <= m_sw2;
      m_age <= t_age;
      m_run <= t_run;
      m_dbp <= m_db;
      m_db  <= t_db;
      m_s2  <= m_s1;
      m_s1  <= t_raw;
      m_sw2 <= m_sw1;
      m_sw1 <= bus.SW;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int up_log[$];
  int dn_log[$];
  int ld_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, compare against the model, log pulses
  task automatic tick();
    @(negedge CLK);
    chk("load", 32'(bus.Load), 32'(e_ld));
    chk("up",   32'(bus.Up),   32'(e_up));
    chk("down", 32'(bus.Down), 32'(e_dn));
    chk("in",   32'(bus.IN),   32'(e_in));
    chk("onehot", 32'($countones({bus.Load, bus.Up, bus.Down}) <= 1), 32'd1);
    if (bus.Up   === 1'b1) up_log.push_back(cyc);
    if (bus.Down === 1'b1) dn_log.push_back(cyc);
    if (bus.Load === 1'b1) ld_log.push_back(cyc);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    up_log.delete();
    dn_log.delete();
    ld_log.delete();
  endtask

  task automatic chk_log(input string tag, input int lg[$], input int base, input int off[$]);
    chk({tag, "_count"}, 32'(lg.size()), 32'(off.size()));
    for (int k = 0; k < lg.size() && k < off.size(); k++)
      chk({tag, "_at"}, 32'(lg[k] - base), 32'(off[k]));
  endtask

  int t0, r0;
  int hold_cnt [3];
  int none[$];

  initial begin
    bus.BTN_UP = 1'b0;
    bus.BTN_DN = 1'b0;
    bus.BTN_LD = 1'b0;
    bus.SW     = '0;
    bus.High   = 1'b0;
    bus.Low    = 1'b0;

    // Reset state
    run(3);
    chk("rst_load", 32'(bus.Load), 32'd0);
    chk("rst_up",   32'(bus.Up),   32'd0);
    chk("rst_down", 32'(bus.Down), 32'd0);
    chk("rst_in",   32'(bus.IN),   32'd0);
    RST = 1'b0;
    run(5);

    // Clean up press: single pulse on the 7th edge
    clear_logs();
    t0 = cyc;
    bus.BTN_UP = 1'b1;
    run(6);
    bus.BTN_UP = 1'b0;
    run(30);
    chk_log("clean_up", up_log, t0, '{7});
    chk_log("clean_dn", dn_log, t0, none);
    chk_log("clean_ld", ld_log, t0, none);

    // Glitch on down is filtered; a long enough press gives one pulse
    clear_logs();
    bus.BTN_DN = 1'b1;
    run(3);
    bus.BTN_DN = 1'b0;
    run(15);
    chk_log("glitch_dn", dn_log, 0, none);
    clear_logs();
    t0 = cyc;
    bus.BTN_DN = 1'b1;
    run(7);
    bus.BTN_DN = 1'b0;
    run(30);
    chk_log("press_dn", dn_log, t0, '{7});

    // Held up: first pulse, delayed repeat, periodic repeat until db falls
    clear_logs();
    t0 = cyc;
    bus.BTN_UP = 1'b1;
    run(7 + 30);
    bus.BTN_UP = 1'b0;
    run(40);
    chk_log("hold_up", up_log, t0 + 7, '{0, 8, 12, 16, 20, 24, 28, 32, 36});

    // High blocks up commands entirely
    clear_logs();
    bus.High = 1'b1;
    bus.BTN_UP = 1'b1;
    run(6);
    bus.BTN_UP = 1'b0;
    run(25);
    chk_log("high_up", up_log, 0, none);
    bus.High = 1'b0;

    // Load captures the switches and holds them
    bus.SW = 5'b10110;
    run(4);
    clear_logs();
    t0 = cyc;
    bus.BTN_LD = 1'b1;
    run(7);
    chk("ld_pulse", 32'(bus.Load), 32'd1);
    chk("ld_in",    32'(bus.IN),   32'b10110);
    run(3);
    bus.BTN_LD = 1'b0;
    bus.SW = 5'b01001;
    run(20);
    chk("ld_hold_in", 32'(bus.IN), 32'b10110);
    chk_log("ld_once", ld_log, t0, '{7});

    // Low suppresses down until released mid-repeat
    clear_logs();
    bus.Low = 1'b1;
    t0 = cyc;
    bus.BTN_DN = 1'b1;
    run(7 + 14);
    bus.Low = 1'b0;
    run(8);
    bus.BTN_DN = 1'b0;
    run(40);
    chk_log("low_dn", dn_log, t0 + 7, '{16, 20, 24, 28});

    // Simultaneous presses: load wins, down beats up on repeats, reset aborts
    clear_logs();
    t0 = cyc;
    bus.BTN_LD = 1'b1;
    bus.BTN_DN = 1'b1;
    bus.BTN_UP = 1'b1;
    run(7 + 18);
    chk_log("all_ld", ld_log, t0 + 7, '{0});
    chk_log("all_dn", dn_log, t0 + 7, '{8, 12, 16});
    chk_log("all_up", up_log, t0 + 7, none);
    RST = 1'b1;
    #1;
    chk("midrst_load", 32'(bus.Load), 32'd0);
    chk("midrst_up",   32'(bus.Up),   32'd0);
    chk("midrst_down", 32'(bus.Down), 32'd0);
    chk("midrst_in",   32'(bus.IN),   32'd0);
    run(3);
    r0 = cyc;
    RST = 1'b0;
    clear_logs();
    run(7);
    chk("rerel_load", 32'(bus.Load), 32'd1);
    chk("rerel_in",   32'(bus.IN),   32'b01001);
    run(3);
    bus.BTN_LD = 1'b0;
    bus.BTN_DN = 1'b0;
    bus.BTN_UP = 1'b0;
    run(30);
    chk_log("rerel_ld", ld_log, r0, '{7});

    // Random activity against the model
    for (int i = 0; i < 3; i++) hold_cnt[i] = 1;
    repeat (1500) begin
      for (int i = 0; i < 3; i++) begin
        hold_cnt[i]--;
        if (hold_cnt[i] == 0) begin
          hold_cnt[i] = int'($urandom_range(1, 24));
          case (i)
            0:       bus.BTN_UP = ~bus.BTN_UP;
            1:       bus.BTN_DN = ~bus.BTN_DN;
            default: bus.BTN_LD = ~bus.BTN_LD;
          endcase
        end
      end
      if ($urandom_range(0, 15) == 0) bus.SW = W'($urandom);
      if ($urandom_range(0, 19) == 0) bus.High = ~bus.High;
      if ($urandom_range(0, 19) == 0) bus.Low = ~bus.Low;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
